// File: rtl/trgg_rsp.sv
// Two-lane trigger counter with a per-lane serial readout to a remote reader.
// Optional macro TRGG_RSP_PARITY_EN appends an even-parity bit to each frame.
module trgg_rsp (
   input  logic        clk,
   input  logic        rst,
   input  logic        fs,
   output logic        fd,
   input  logic [0:1]  pin_in,
   input  logic [0:1]  cs,
   input  logic [0:1]  sclk,
   output logic [0:1]  dout,
   output logic [0:31] cnt
);

`ifdef TRGG_RSP_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif
   localparam logic [4:0] LAST_BIT = 5'(NB - 1);

   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

   logic [0:1] done_set;
   logic [0:1] done_flag;
   logic       fd_q;

   for (genvar i = 0; i < 2; i++) begin : g_lane
      // bit [0] is the first synchronizer flop, bit [2] the edge-detect stage
      logic [2:0]    pin_sy, cs_sy, sclk_sy;
      logic          pin_rise, cs_fall, cs_high, sclk_rise, sclk_fall;
      logic          load_go;
      logic [15:0]   cnt_q;
      logic [0:NB-1] sh_q;
      logic [0:NB-1] ld_val;
      logic [4:0]    bit_q;
      logic          dout_l;
      logic          done_l;
      state_t        state_q, state_d;

      assign pin_rise  = pin_sy[1] & ~pin_sy[2];
      assign cs_fall   = ~cs_sy[1] & cs_sy[2];
      assign cs_high   = cs_sy[1];
      assign sclk_rise = sclk_sy[1] & ~sclk_sy[2];
      assign sclk_fall = ~sclk_sy[1] & sclk_sy[2];
      assign load_go   = (state_q == IDLE) && cs_fall;

`ifdef TRGG_RSP_PARITY_EN
      assign ld_val = {cnt_q, ^cnt_q};
`else
      assign ld_val = cnt_q;
`endif

      always_ff @(posedge clk) begin
         if (rst) begin
            state_q <= IDLE;
         end else begin
            state_q <= state_d;
         end
      end

      always_comb begin
         state_d = state_q;
         case (state_q)
            IDLE:    if (cs_fall) state_d = LOAD;
            LOAD:    state_d = cs_high ? IDLE : SHIFT;
            SHIFT: begin
               if (cs_high) state_d = IDLE;
               else if (sclk_rise && (bit_q == LAST_BIT)) state_d = DONE;
            end
            DONE:    if (cs_high) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end

      always_comb begin
         dout_l = 1'b0;
         done_l = 1'b0;
         if ((state_q == LOAD) || (state_q == SHIFT)) dout_l = sh_q[0];
         if ((state_d == DONE) && (state_q != DONE)) done_l = 1'b1;
      end

      // The snapshot is taken on the edge entering LOAD so dout is valid
      // throughout LOAD; a coincident trigger seeds the new window with 1.
      always_ff @(posedge clk) begin
         if (rst) begin
            pin_sy  <= '0;
            cs_sy   <= '0;
            sclk_sy <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            bit_q   <= '0;
         end else begin
            pin_sy  <= {pin_sy[1:0], pin_in[i]};
            cs_sy   <= {cs_sy[1:0], cs[i]};
            sclk_sy <= {sclk_sy[1:0], sclk[i]};
            if (load_go) begin
               cnt_q <= {15'd0, pin_rise & fs};
               sh_q  <= ld_val;
               bit_q <= '0;
            end else begin
               if (pin_rise && fs && (cnt_q != 16'hFFFF)) cnt_q <= cnt_q + 16'd1;
               if (state_q == SHIFT) begin
                  if (sclk_fall) sh_q <= {sh_q[1:NB-1], 1'b0};
                  if (sclk_rise) bit_q <= bit_q + 5'd1;
               end
            end
         end
      end

      assign dout[i]         = dout_l;
      assign done_set[i]     = done_l;
      assign cnt[16*i +: 16] = cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done_flag <= '0;
         fd_q      <= 1'b0;
      end else begin
         fd_q      <= &done_flag;
         done_flag <= (&done_flag) ? done_set : (done_flag | done_set);
      end
   end

   assign fd = fd_q;

endmodule

// File: tb/tb_trgg_rsp.sv
// Directed bench for trgg_rsp: counting, readout frames, saturation, abort and fd.
module tb_trgg_rsp;

`ifdef TRGG_RSP_PARITY_EN
   localparam int NB = 17;
`else
   localparam int NB = 16;
`endif

   logic        clk;
   logic        rst;
   logic        fs;
   logic        fd;
   logic [0:1]  pin_in;
   logic [0:1]  cs;
   logic [0:1]  sclk;
   logic [0:1]  dout;
   logic [0:31] cnt;

   int total;
   int bad;
   int fd_cycles;
   int fd_pulses;
   logic fd_prev;

   trgg_rsp dut (
      .clk    (clk),
      .rst    (rst),
      .fs     (fs),
      .fd     (fd),
      .pin_in (pin_in),
      .cs     (cs),
      .sclk   (sclk),
      .dout   (dout),
      .cnt    (cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial fd_prev = 1'b0;
   always @(negedge clk) begin
      if (fd === 1'b1) begin
         fd_cycles++;
         if (fd_prev !== 1'b1) fd_pulses++;
      end
      fd_prev = fd;
   end

   function automatic logic [16:0] frame_exp(input logic [15:0] v);
`ifdef TRGG_RSP_PARITY_EN
      return {v, ^v};
`else
      return {1'b0, v};
`endif
   endfunction

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      cs     = 2'b11;
      sclk   = 2'b00;
      pin_in = 2'b00;
      wait_clks(3);
      rst = 1'b0;
      wait_clks(2);
   endtask

   task automatic pulse_pin(input int lane, input int n);
      for (int k = 0; k < n; k++) begin
         pin_in[lane] = 1'b1;
         wait_clks(2);
         pin_in[lane] = 1'b0;
         wait_clks(2);
      end
      wait_clks(4);
   endtask

   task automatic read_frame(input int lane, input int nclk, input bit with_pulse,
                             output logic [16:0] val, output logic dout_end);
      val = '0;
      cs[lane] = 1'b0;
      if (with_pulse) pin_in[lane] = 1'b1;
      wait_clks(2);
      if (with_pulse) pin_in[lane] = 1'b0;
      wait_clks(4);
      for (int k = 0; k < nclk; k++) begin
         val = {val[15:0], dout[lane]};
         sclk[lane] = 1'b1;
         wait_clks(8);
         sclk[lane] = 1'b0;
         wait_clks(8);
      end
      dout_end = dout[lane];
      cs[lane] = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_reset();
      do_reset();
      fs = 1'b1;
      pulse_pin(0, 3);
      total++;
      if (cnt[0:15] !== 16'd3) begin
         bad++; $display("FAIL pre_reset_cnt: got %h want %h", cnt[0:15], 16'd3);
      end
      rst = 1'b1;
      wait_clks(1);
      total++;
      if (cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %h want 0", cnt); end
      total++;
      if (fd !== 1'b0) begin bad++; $display("FAIL reset_fd: got %b want 0", fd); end
      total++;
      if (dout !== 2'b00) begin bad++; $display("FAIL reset_dout: got %b want 00", dout); end
      rst = 1'b0;
      wait_clks(2);
   endtask

   task automatic test_count_frame();
      logic [16:0] v;
      logic        de;
      int          p0;
      do_reset();
      fs = 1'b1;
      p0 = fd_pulses;
      pulse_pin(0, 5);
      total++;
      if (cnt[0:15] !== 16'd5) begin bad++; $display("FAIL count5: got %h want 0005", cnt[0:15]); end
      total++;
      if (cnt[16:31] !== 16'd0) begin bad++; $display("FAIL count5_lane1: got %h want 0000", cnt[16:31]); end
      read_frame(0, NB, 1'b0, v, de);
      total++;
      if (v !== frame_exp(16'h0005)) begin bad++; $display("FAIL frame5: got %h want %h", v, frame_exp(16'h0005)); end
      total++;
      if (de !== 1'b0) begin bad++; $display("FAIL done_dout: got %b want 0", de); end
      total++;
      if (cnt[0:15] !== 16'd0) begin bad++; $display("FAIL cleared_after_load: got %h want 0000", cnt[0:15]); end
      total++;
      if (fd_pulses - p0 !== 0) begin bad++; $display("FAIL fd_one_lane: got %0d want 0", fd_pulses - p0); end
   endtask

   task automatic test_disarmed();
      logic [16:0] v;
      logic        de;
      do_reset();
      fs = 1'b0;
      pulse_pin(1, 3);
      total++;
      if (cnt[16:31] !== 16'd0) begin bad++; $display("FAIL disarmed_cnt: got %h want 0000", cnt[16:31]); end
      read_frame(1, NB, 1'b0, v, de);
      total++;
      if (v !== frame_exp(16'h0000)) begin bad++; $display("FAIL disarmed_frame: got %h want %h", v, frame_exp(16'h0000)); end
   endtask

   task automatic test_saturate();
      logic [16:0] v;
      logic        de;
      do_reset();
      fs = 1'b1;
      force dut.g_lane[0].cnt_q = 16'hfff0;
      wait_clks(1);
      release dut.g_lane[0].cnt_q;
      wait_clks(1);
      pulse_pin(0, 20);
      total++;
      if (cnt[0:15] !== 16'hFFFF) begin bad++; $display("FAIL saturate: got %h want ffff", cnt[0:15]); end
      read_frame(0, NB, 1'b0, v, de);
      total++;
      if (v !== frame_exp(16'hFFFF)) begin bad++; $display("FAIL saturate_frame: got %h want %h", v, frame_exp(16'hFFFF)); end
   endtask

   task automatic test_coincident();
      logic [16:0] v;
      logic        de;
      do_reset();
      fs = 1'b1;
      pulse_pin(0, 2);
      read_frame(0, NB, 1'b1, v, de);
      total++;
      if (v !== frame_exp(16'h0002)) begin bad++; $display("FAIL coincident_frame: got %h want %h", v, frame_exp(16'h0002)); end
      total++;
      if (cnt[0:15] !== 16'd1) begin bad++; $display("FAIL coincident_cnt: got %h want 0001", cnt[0:15]); end
   endtask

   task automatic test_abort();
      logic [16:0] v;
      logic        de;
      int          p0;
      do_reset();
      fs = 1'b1;
      p0 = fd_pulses;
      pulse_pin(1, 3);
      read_frame(1, 7, 1'b0, v, de);
      total++;
      if (dout[1] !== 1'b0) begin bad++; $display("FAIL abort_dout: got %b want 0", dout[1]); end
      total++;
      if (cnt[16:31] !== 16'd0) begin bad++; $display("FAIL abort_cnt: got %h want 0000", cnt[16:31]); end
      read_frame(0, NB, 1'b0, v, de);
      total++;
      if (fd_pulses - p0 !== 0) begin bad++; $display("FAIL abort_no_fd: got %0d want 0", fd_pulses - p0); end
      read_frame(1, NB, 1'b0, v, de);
      total++;
      if (v !== frame_exp(16'h0000)) begin bad++; $display("FAIL after_abort_frame: got %h want %h", v, frame_exp(16'h0000)); end
      total++;
      if (fd_pulses - p0 !== 1) begin bad++; $display("FAIL after_abort_fd: got %0d want 1", fd_pulses - p0); end
   endtask

   task automatic test_back_to_back();
      logic [16:0] v0, v1;
      logic        d0, d1;
      int          p0, c0;
      do_reset();
      fs = 1'b1;
      p0 = fd_pulses;
      c0 = fd_cycles;
      pulse_pin(0, 1);
      pulse_pin(1, 2);
      fork
         read_frame(0, NB, 1'b0, v0, d0);
         read_frame(1, NB, 1'b0, v1, d1);
      join
      total++;
      if (v0 !== frame_exp(16'h0001)) begin bad++; $display("FAIL both_frame0: got %h want %h", v0, frame_exp(16'h0001)); end
      total++;
      if (v1 !== frame_exp(16'h0002)) begin bad++; $display("FAIL both_frame1: got %h want %h", v1, frame_exp(16'h0002)); end
      total++;
      if (fd_pulses - p0 !== 1) begin bad++; $display("FAIL both_fd_pulses: got %0d want 1", fd_pulses - p0); end
      total++;
      if (fd_cycles - c0 !== 1) begin bad++; $display("FAIL both_fd_width: got %0d want 1", fd_cycles - c0); end
   endtask

   task automatic test_mid_reset();
      logic [16:0] v;
      logic        de;
      int          p0;
      do_reset();
      fs = 1'b1;
      p0 = fd_pulses;
      pulse_pin(1, 4);
      read_frame(0, NB, 1'b0, v, de);
      pulse_pin(1, 1);
      cs[1] = 1'b0;
      wait_clks(6);
      for (int k = 0; k < 3; k++) begin
         sclk[1] = 1'b1;
         wait_clks(8);
         sclk[1] = 1'b0;
         wait_clks(8);
      end
      rst = 1'b1;
      wait_clks(2);
      total++;
      if ({dout, fd} !== 3'b000) begin bad++; $display("FAIL mid_reset_out: got %b want 000", {dout, fd}); end
      rst = 1'b0;
      cs[1] = 1'b1;
      wait_clks(6);
      read_frame(1, NB, 1'b0, v, de);
      total++;
      if (fd_pulses - p0 !== 0) begin bad++; $display("FAIL mid_reset_fd: got %0d want 0", fd_pulses - p0); end
   endtask

   task automatic test_parity();
      logic [16:0] v;
      logic        de;
      do_reset();
      fs = 1'b1;
      pulse_pin(1, 7);
      read_frame(1, NB, 1'b0, v, de);
      total++;
      if (v !== frame_exp(16'h0007)) begin bad++; $display("FAIL frame7: got %h want %h", v, frame_exp(16'h0007)); end
`ifdef TRGG_RSP_PARITY_EN
      total++;
      if (v[0] !== 1'b1) begin bad++; $display("FAIL parity_bit: got %b want 1", v[0]); end
`endif
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      fd_cycles = 0;
      fd_pulses = 0;
      rst       = 1'b1;
      fs        = 1'b0;
      cs        = 2'b11;
      sclk      = 2'b00;
      pin_in    = 2'b00;
      test_reset();
      test_count_frame();
      test_disarmed();
      test_saturate();
      test_coincident();
      test_abort();
      test_back_to_back();
      test_mid_reset();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trgg_rsp.md
TRGG_RSP -- requirements
Module: trgg_rsp

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state SHALL be updated on its rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 fs  input  1  arm; trigger events SHALL be counted only while fs=1.
REQ-005 fd  output  1  one-cycle pulse when both lanes have each completed a full frame since the last fd.
REQ-006 pin_in  input  [0:1]  asynchronous trigger inputs, one per lane.
REQ-007 cs  input  [0:1]  per-lane chip select from the remote reader, active-low, asynchronous.
REQ-008 sclk  input  [0:1]  per-lane serial clock from the remote reader, idle-low, asynchronous, period at least 8 clk.
REQ-009 dout  output  [0:1]  per-lane serial data to the remote reader's din; the reader samples on the sclk rising edge.
REQ-010 cnt  output  [0:31]  live event counters, lane 0 in [0:15] and lane 1 in [16:31].

Function
REQ-011 Each of pin_in, cs and sclk SHALL pass through a 2-flop synchronizer, followed by one registered stage for edge detection.
REQ-012 A pin_in rising edge with fs=1 SHALL increment that lane's 16-bit counter 3 clk after the edge reaches the first synchronizer flop.
REQ-013 The counter SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-014 Each lane SHALL implement the states IDLE, LOAD, SHIFT and DONE, independently of the other lane.
REQ-015 IDLE->LOAD on a detected cs falling edge.
REQ-016 LOAD lasts 1 clk: the counter SHALL be copied into a 16-bit shift register and the counter SHALL be cleared.
REQ-017 A pin_in event coincident with LOAD SHALL count as 1 in the new window and SHALL NOT be lost.
REQ-018 In LOAD, dout SHALL present the shift register MSB (bit [0]); the block SHALL then enter SHIFT.
REQ-019 In SHIFT, each detected sclk falling edge SHALL advance dout to the next bit.
REQ-020 The block SHALL count detected sclk rising edges, and after the last data bit's rising edge SHALL enter DONE.
REQ-021 DONE SHALL drive dout=0 and SHALL return to IDLE when cs is deasserted.
REQ-022 A cs deassertion while in LOAD or SHIFT SHALL abort the frame: remaining bits are dropped, the counter is not restored, the lane goes to IDLE, and no completion is recorded.
REQ-023 dout SHALL be 0 in IDLE.
REQ-024 Per-lane completion flags SHALL be set on entry to DONE.
REQ-025 When both completion flags are set, fd SHALL pulse for 1 clk and both flags SHALL clear in the same cycle.
REQ-026 If both lanes enter DONE in the same cycle, fd SHALL pulse on the next cycle.
REQ-027 sclk edges while in IDLE or DONE SHALL be ignored.
REQ-028 A cs falling edge while in DONE SHALL be ignored until cs has been seen high.

Reset
REQ-029 On rst=1, all states SHALL go to IDLE, and counters, shift registers, bit counters, completion flags and synchronizers SHALL clear.
REQ-030 On rst=1, dout SHALL be 0, fd SHALL be 0 and cnt SHALL be 0, from the first rising clk edge with rst=1.
REQ-031 A reset mid-frame SHALL discard the frame without any fd pulse.

Configuration
REQ-032 Macro TRGG_RSP_PARITY_EN, when defined, SHALL make each frame 17 bits: 16 data bits followed by 1 even-parity bit over the data, computed at LOAD; DONE is entered after the 17th sclk rising edge.
REQ-033 Without TRGG_RSP_PARITY_EN, each frame SHALL be exactly 16 bits, with no parity logic.

Verification
REQ-034 fs=1; 5 pulses on pin_in[0]; lane 0 frame with 16 sclk pulses -> reader captures 0x0005; cnt[0:15]=0 after LOAD.
REQ-035 fs=0; 3 pulses on pin_in[1] -> cnt[16:31] stays 0; frame reads 0x0000.
REQ-036 70000 pulses on pin_in[0] -> cnt[0:15]=0xFFFF; frame reads 0xFFFF.
REQ-037 Pulse on pin_in[0] coincident with LOAD -> frame reads the prior value; cnt[0:15]=1 afterwards.
REQ-038 cs raised after 7 sclk pulses on lane 1 -> lane 1 back in IDLE, no fd.
REQ-039 Full frames on both lanes -> exactly one 1-clk fd pulse.
REQ-040 With TRGG_RSP_PARITY_EN defined and a value of 0x0007 -> 17th bit = 1.
